// File: rtl/service_arbiter.sv
//============================================================================
// Module      : service_arbiter
// Description : Grants the shared display bus and push buttons to one of four
//               services, with blanked handover, alarm pre-emption and
//               finish-pulse retirement.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module service_arbiter #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  svc_sw,
    input  logic        alarm_req,
    input  logic [3:0]  finish,
    input  logic [4:0]  push,
    input  logic [15:0] time_in,
    input  logic [63:0] disp_in,
    output logic [3:0]  grant,
    output logic [4:0]  push_out,
    output logic [15:0] disp_out,
    output logic        disp_blank,
    output logic [3:0]  svc_led,
    output logic        conflict
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HANDOVER = 3'd1,
        S_OWNED    = 3'd2,
        S_DONE     = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       pending, pending_nxt;
    logic [3:0]       owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       mask, push_q, push_rise;
    logic [3:0]       eff_req;
    logic             multi;

    assign multi     = ($countones(svc_sw) > 1);
    assign eff_req   = ($countones(svc_sw) == 1) ? svc_sw : 4'b0000;
    assign push_rise = push & ~push_q & ~mask;

    function automatic logic [15:0] owner_digits(input logic [3:0] o, input logic [63:0] d);
        case (o)
            4'b1000: owner_digits = d[63:48];
            4'b0100: owner_digits = d[47:32];
            4'b0010: owner_digits = d[31:16];
            4'b0001: owner_digits = d[15:0];
            default: owner_digits = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        if (alarm_req) begin
            state_nxt = S_ALARM;
        end else begin
            case (state)
                S_IDLE: begin
                    if (eff_req != 4'b0000) begin
                        state_nxt   = S_HANDOVER;
                        pending_nxt = eff_req;
                        cnt_nxt     = CNT_INIT;
                    end
                end
                S_HANDOVER: begin
                    if (eff_req == 4'b0000) begin
                        state_nxt = S_IDLE;
                    end else if (eff_req != pending) begin
                        pending_nxt = eff_req;
                        cnt_nxt     = CNT_INIT;
                    end else if (cnt == '0) begin
                        state_nxt = S_OWNED;
                        owner_nxt = pending;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_OWNED: begin
                    // A finish pulse outranks a simultaneous switch change.
                    if ((finish & owner) != 4'b0000) begin
                        state_nxt = S_DONE;
                    end else if (eff_req == 4'b0000) begin
                        state_nxt = S_IDLE;
                    end else if (eff_req != owner) begin
                        state_nxt   = S_HANDOVER;
                        pending_nxt = eff_req;
                        cnt_nxt     = CNT_INIT;
                    end
                end
                S_DONE: begin
                    if (eff_req != owner) state_nxt = S_IDLE;
                end
                S_ALARM:  state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pending    <= 4'b0000;
            owner      <= 4'b0000;
            cnt        <= '0;
            mask       <= 5'b00000;
            push_q     <= 5'b00000;
            grant      <= 4'b0000;
            push_out   <= 5'b00000;
            disp_out   <= 16'h0000;
            disp_blank <= 1'b0;
            svc_led    <= 4'b0000;
            conflict   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            owner      <= owner_nxt;
            cnt        <= cnt_nxt;
            push_q     <= push;
            conflict   <= multi;
            grant      <= 4'b0000;
            svc_led    <= 4'b0000;
            disp_blank <= 1'b0;
            disp_out   <= time_in;
            push_out   <= 5'b00000;
            mask       <= mask & push;
            // Buttons already held when a service gains the bus stay muted until released.
            if (state_nxt == S_OWNED || state_nxt == S_ALARM) begin
                if (state_nxt != state) mask     <= push;
                else                    push_out <= push_rise;
            end
            case (state_nxt)
                S_HANDOVER: begin
                    disp_blank <= 1'b1;
                    svc_led    <= pending_nxt;
                end
                S_OWNED: begin
                    grant    <= owner_nxt;
                    svc_led  <= owner_nxt;
                    disp_out <= owner_digits(owner_nxt, disp_in);
                end
                S_ALARM: begin
                    grant    <= 4'b0001;
                    svc_led  <= 4'b0001;
                    disp_out <= disp_in[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_service_arbiter.sv
//============================================================================
// Module      : tb_service_arbiter
// Description : Directed self-checking bench for service_arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_service_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  svc_sw;
    logic        alarm_req;
    logic [3:0]  finish;
    logic [4:0]  push;
    logic [15:0] time_in;
    logic [63:0] disp_in;
    logic [3:0]  grant;
    logic [4:0]  push_out;
    logic [15:0] disp_out;
    logic        disp_blank;
    logic [3:0]  svc_led;
    logic        conflict;

    int tests  = 0;
    int failed = 0;

    localparam logic [15:0] TIME_V = 16'h0930;
    localparam logic [15:0] S1_V   = 16'h1234;
    localparam logic [15:0] S2_V   = 16'h5678;
    localparam logic [15:0] S3_V   = 16'h2468;
    localparam logic [15:0] S4_V   = 16'h1357;

    service_arbiter #(.BLANK_CYCLES(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .svc_sw     (svc_sw),
        .alarm_req  (alarm_req),
        .finish     (finish),
        .push       (push),
        .time_in    (time_in),
        .disp_in    (disp_in),
        .grant      (grant),
        .push_out   (push_out),
        .disp_out   (disp_out),
        .disp_blank (disp_blank),
        .svc_led    (svc_led),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_like(input string tag, input logic [15:0] exp_disp);
        check({tag, "_grant"}, 64'(grant), 64'h0);
        check({tag, "_led"},   64'(svc_led), 64'h0);
        check({tag, "_disp"},  64'(disp_out), 64'(exp_disp));
        check({tag, "_blank"}, 64'(disp_blank), 64'h0);
    endtask

    task automatic check_owned(input string tag, input logic [3:0] o, input logic [15:0] d);
        check({tag, "_grant"}, 64'(grant), 64'(o));
        check({tag, "_led"},   64'(svc_led), 64'(o));
        check({tag, "_disp"},  64'(disp_out), 64'(d));
        check({tag, "_blank"}, 64'(disp_blank), 64'h0);
    endtask

    // Four blanked cycles announcing led, each one cycle after the previous.
    task automatic check_blanking(input string tag, input logic [3:0] led);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_blank"}, 64'(disp_blank), 64'h1);
            check({tag, "_hgrant"}, 64'(grant), 64'h0);
            check({tag, "_hled"}, 64'(svc_led), 64'(led));
            tick(1);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        svc_sw    = 4'b0000;
        alarm_req = 1'b0;
        finish    = 4'b0000;
        push      = 5'b00000;
        time_in   = TIME_V;
        disp_in   = {S1_V, S2_V, S3_V, S4_V};
        tick(2);

        check_idle_like("reset", 16'h0000);
        check("reset_push", 64'(push_out), 64'h0);
        check("reset_conflict", 64'(conflict), 64'h0);

        // Service 1 request: four blank cycles, then ownership. Up held during handover.
        resetn = 1'b1;
        svc_sw = 4'b1000;
        tick(1);
        push = 5'b00001;
        check_blanking("s1_hand", 4'b1000);
        check_owned("s1_own", 4'b1000, S1_V);
        check("s1_entry_push", 64'(push_out), 64'h0);
        tick(2);
        check("s1_held_push", 64'(push_out), 64'h0);
        push = 5'b00000;
        tick(1);
        check("s1_release_push", 64'(push_out), 64'h0);
        push = 5'b00001;
        tick(1);
        check("s1_press_pulse", 64'(push_out), 64'h01);
        tick(1);
        check("s1_press_single", 64'(push_out), 64'h0);
        push = 5'b00000;
        tick(1);

        // Two switches on: conflict, owner released.
        svc_sw = 4'b1010;
        tick(1);
        check("conf_flag", 64'(conflict), 64'h1);
        check_idle_like("conf", TIME_V);
        svc_sw = 4'b0010;
        tick(1);
        check("conf_clear", 64'(conflict), 64'h0);
        check_blanking("s3_hand", 4'b0010);
        check_owned("s3_own", 4'b0010, S3_V);

        // Move to service 2, then retire it with a finish pulse.
        svc_sw = 4'b0100;
        tick(1);
        check_blanking("s2_hand", 4'b0100);
        check_owned("s2_own", 4'b0100, S2_V);
        finish = 4'b0001;
        tick(1);
        finish = 4'b0000;
        check_owned("s2_nonowner_fin", 4'b0100, S2_V);
        finish = 4'b0100;
        tick(1);
        finish = 4'b0000;
        check_idle_like("s2_done", TIME_V);
        tick(3);
        check_idle_like("s2_done_hold", TIME_V);
        svc_sw = 4'b0000;
        tick(1);
        check_idle_like("s2_lowered", TIME_V);
        svc_sw = 4'b0100;
        tick(1);
        check_blanking("s2_rehand", 4'b0100);
        check_owned("s2_reown", 4'b0100, S2_V);

        // Alarm pre-empts a handover in progress to service 3.
        svc_sw = 4'b0010;
        tick(2);
        check("alarm_pre_blank", 64'(disp_blank), 64'h1);
        alarm_req = 1'b1;
        tick(1);
        check_owned("alarm", 4'b0001, S4_V);
        push = 5'b00010;
        tick(1);
        check("alarm_push_pulse", 64'(push_out), 64'h02);
        push = 5'b00000;
        alarm_req = 1'b0;
        tick(1);
        check_idle_like("alarm_off", TIME_V);
        check("alarm_off_push", 64'(push_out), 64'h0);
        tick(1);
        check_blanking("post_alarm_hand", 4'b0010);
        check_owned("post_alarm_own", 4'b0010, S3_V);

        // Reset while owned with a fresh middle press must swallow the pulse.
        push   = 5'b10000;
        resetn = 1'b0;
        tick(1);
        check_idle_like("mid_reset", 16'h0000);
        check("mid_reset_push", 64'(push_out), 64'h0);
        check("mid_reset_conflict", 64'(conflict), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
